// File: rtl/exu_wb_arb_pkg.sv
// Shared types for the execute-stage writeback arbiter.
// No logic; widths and the writeback packet layout only.
// Not applicable (no flow control in a package).
package exu_wb_arb_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  // One buffered long-latency result: destination register plus data.
  typedef struct packed {
    logic [RADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]    data;
  } wb_pkt_t;

  // x0 is hardwired to zero, so a write to it is dropped rather than issued.
  function automatic logic rd_live(input logic [RADDR_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of writeback packets with occupancy count.
// Head is valid the cycle after a push (no bypass); pop is zero-latency on head.
// Push is ignored when full unless a pop frees the slot in the same cycle.
module wb_fifo
  import exu_wb_arb_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type pkt_t = wb_pkt_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  pkt_t                   push_pkt,
  input  logic                   pop,
  output pkt_t                   head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  pkt_t          mem_q [DEPTH];
  pkt_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Pointer, storage and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != FULL_CNT) | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_pkt;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the buffer and discards its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/exu_wb_arb.sv
// Register-file writeback arbiter: ALU has priority, long-latency results queue in a FIFO.
// Granted write appears on rf_wr_* one cycle after grant; FIFO head eligible one cycle after push.
// ALU cannot be stalled; a starved FIFO head raises wb_stall_req for an upstream bubble, ll_ready = ~full.
module exu_wb_arb
  import exu_wb_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [XLEN-1:0]               alu_wb_data,
  input  logic [RADDR_W-1:0]            alu_wb_rd_addr,
  input  logic                          alu_wb_rd_wr_en,
  input  logic                          ll_valid,
  input  logic [XLEN-1:0]               ll_data,
  input  logic [RADDR_W-1:0]            ll_rd_addr,
  output logic                          ll_ready,
  output logic                          rf_wr_en,
  output logic [RADDR_W-1:0]            rf_wr_addr,
  output logic [XLEN-1:0]               rf_wr_data,
  output logic                          wb_stall_req,
  output logic [$clog2(FIFO_DEPTH):0]   ll_pending
);

  localparam int               AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  wb_pkt_t                     push_pkt;
  wb_pkt_t                     fifo_head;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        ll_push;

  logic                        alu_eff;
  logic                        grant_alu;
  logic                        grant_ll;

  logic                        rf_wr_en_q,   rf_wr_en_d;
  logic [RADDR_W-1:0]          rf_wr_addr_q, rf_wr_addr_d;
  logic [XLEN-1:0]             rf_wr_data_q, rf_wr_data_d;
  logic [AGE_W-1:0]            age_q,        age_d;
  logic                        stall_q,      stall_d;

  assign push_pkt = '{rd_addr: ll_rd_addr, data: ll_data};
  assign ll_ready = ~fifo_full;
  assign ll_push  = ll_valid & ll_ready;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .pkt_t (wb_pkt_t)
  ) u_wb_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (ll_push),
    .push_pkt (push_pkt),
    .pop      (grant_ll),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Fixed-priority grant: an effective ALU write wins, otherwise the FIFO head drains.
  always_comb begin
    alu_eff   = alu_wb_rd_wr_en & rd_live(alu_wb_rd_addr);
    grant_alu = alu_eff;
    grant_ll  = ~alu_eff & ~fifo_empty;
  end

  // Output register next-state; address/data hold when nothing is written (x0 pops write nothing).
  always_comb begin
    rf_wr_en_d   = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    if (grant_alu) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_addr_d = alu_wb_rd_addr;
      rf_wr_data_d = alu_wb_data;
    end else if (grant_ll && rd_live(fifo_head.rd_addr)) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_addr_d = fifo_head.rd_addr;
      rf_wr_data_d = fifo_head.data;
    end
  end

  // Head age: counts blocked cycles, clears on pop or empty, saturates; stall flop mirrors age >= limit.
  always_comb begin
    age_d = age_q;
    if (fifo_empty || grant_ll) begin
      age_d = '0;
    end else if (age_q < AGE_MAX) begin
      age_d = age_q + 1'b1;
    end
    stall_d = (age_d >= AGE_MAX);
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      age_q        <= '0;
      stall_q      <= 1'b0;
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      age_q        <= age_d;
      stall_q      <= stall_d;
    end
  end

  assign rf_wr_en     = rf_wr_en_q;
  assign rf_wr_addr   = rf_wr_addr_q;
  assign rf_wr_data   = rf_wr_data_q;
  assign wb_stall_req = stall_q;
  assign ll_pending   = fifo_count;

endmodule

// File: tb/tb_exu_wb_arb.sv
// Directed and scoreboarded random bench for exu_wb_arb.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Upstream model honours wb_stall_req with a one-cycle ALU bubble.
module tb_exu_wb_arb;
  import exu_wb_arb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [XLEN-1:0]           alu_wb_data;
  logic [RADDR_W-1:0]        alu_wb_rd_addr;
  logic                      alu_wb_rd_wr_en;
  logic                      ll_valid;
  logic [XLEN-1:0]           ll_data;
  logic [RADDR_W-1:0]        ll_rd_addr;
  logic                      ll_ready;
  logic                      rf_wr_en;
  logic [RADDR_W-1:0]        rf_wr_addr;
  logic [XLEN-1:0]           rf_wr_data;
  logic                      wb_stall_req;
  logic [$clog2(DEPTH):0]    ll_pending;

  int n_checks = 0;
  int n_errors = 0;

  // Random-phase scoreboard state.
  logic [RADDR_W+XLEN-1:0] llq[$];
  logic                    prev_alu;
  logic [RADDR_W-1:0]      prev_rd;
  logic [XLEN-1:0]         prev_data;
  logic                    src_hold;
  int                      seq;
  int                      n_ll_wr;

  always #5 clk = ~clk;

  exu_wb_arb #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_wb_data     (alu_wb_data),
    .alu_wb_rd_addr  (alu_wb_rd_addr),
    .alu_wb_rd_wr_en (alu_wb_rd_wr_en),
    .ll_valid        (ll_valid),
    .ll_data         (ll_data),
    .ll_rd_addr      (ll_rd_addr),
    .ll_ready        (ll_ready),
    .rf_wr_en        (rf_wr_en),
    .rf_wr_addr      (rf_wr_addr),
    .rf_wr_data      (rf_wr_data),
    .wb_stall_req    (wb_stall_req),
    .ll_pending      (ll_pending)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_drive(input logic en, input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] d);
    alu_wb_rd_wr_en = en;
    alu_wb_rd_addr  = rd;
    alu_wb_data     = d;
  endtask

  task automatic ll_drive(input logic v, input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] d);
    ll_valid   = v;
    ll_rd_addr = rd;
    ll_data    = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},      rf_wr_en,     1'b0);
    check({tag, "_addr"},    rf_wr_addr,   '0);
    check({tag, "_data"},    rf_wr_data,   '0);
    check({tag, "_stall"},   wb_stall_req, 1'b0);
    check({tag, "_pending"}, ll_pending,   '0);
    check({tag, "_ready"},   ll_ready,     1'b1);
  endtask

  // Checks the write registered at the previous edge against the scoreboard.
  task automatic rnd_observe();
    logic [RADDR_W+XLEN-1:0] e;
    if (prev_alu) begin
      check("rnd_alu_en",   rf_wr_en,   1'b1);
      check("rnd_alu_addr", rf_wr_addr, prev_rd);
      check("rnd_alu_data", rf_wr_data, prev_data);
    end else if (rf_wr_en) begin
      if (llq.size() == 0) begin
        check("rnd_spurious_wr", rf_wr_en, 1'b0);
      end else begin
        e = llq.pop_front();
        n_ll_wr++;
        check("rnd_ll_addr", rf_wr_addr, e[RADDR_W+XLEN-1:XLEN]);
        check("rnd_ll_data", rf_wr_data, e[XLEN-1:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    alu_drive(1'b0, 5'd0, '0);
    ll_drive(1'b0, 5'd0, '0);
    #2;
    check_reset_outputs("reset");
    cyc();
    cyc();
    rst = 1'b0;

    // Idle ALU: push at cycle N, write visible at N+2.
    ll_drive(1'b1, 5'd5, 32'hDEAD_BEEF);
    cyc();
    ll_valid = 1'b0;
    check("a_pending_after_push", ll_pending, 2'd1);
    check("a_no_bypass_en", rf_wr_en, 1'b0);
    cyc();
    check("a_wr_en",   rf_wr_en,   1'b1);
    check("a_wr_addr", rf_wr_addr, 5'd5);
    check("a_wr_data", rf_wr_data, 32'hDEAD_BEEF);
    check("a_pending_drained", ll_pending, 2'd0);

    // Busy ALU starves two queued entries; stall bubbles drain them one at a time.
    alu_drive(1'b1, 5'd3, 32'h11);
    ll_drive(1'b1, 5'd10, 32'hA0);
    cyc();
    check("b_alu_addr", rf_wr_addr, 5'd3);
    check("b_alu_data", rf_wr_data, 32'h11);
    ll_drive(1'b1, 5'd11, 32'hA1);
    cyc();
    ll_valid = 1'b0;
    check("b_ready_full", ll_ready, 1'b0);
    check("b_pending_full", ll_pending, 2'd2);
    check("b_stall_age1", wb_stall_req, 1'b0);
    cyc();
    cyc();
    check("b_stall_age3", wb_stall_req, 1'b0);
    cyc();
    check("b_stall_age4", wb_stall_req, 1'b1);
    check("b_alu_still_wins", rf_wr_addr, 5'd3);
    alu_wb_rd_wr_en = 1'b0;
    cyc();
    check("b_pop1_en",      rf_wr_en,     1'b1);
    check("b_pop1_addr",    rf_wr_addr,   5'd10);
    check("b_pop1_data",    rf_wr_data,   32'hA0);
    check("b_pop1_stall",   wb_stall_req, 1'b0);
    check("b_pop1_pending", ll_pending,   2'd1);
    check("b_pop1_ready",   ll_ready,     1'b1);
    alu_wb_rd_wr_en = 1'b1;
    cyc();
    cyc();
    cyc();
    check("b_stall2_age3", wb_stall_req, 1'b0);
    cyc();
    check("b_stall2_age4", wb_stall_req, 1'b1);
    alu_wb_rd_wr_en = 1'b0;
    cyc();
    check("b_pop2_addr",    rf_wr_addr, 5'd11);
    check("b_pop2_data",    rf_wr_data, 32'hA1);
    check("b_pop2_pending", ll_pending, 2'd0);

    // Full FIFO draining while the source holds: order 7, 8, 9 and push+pop keeps occupancy.
    alu_drive(1'b1, 5'd3, 32'h22);
    ll_drive(1'b1, 5'd7, 32'h77);
    cyc();
    ll_drive(1'b1, 5'd8, 32'h88);
    cyc();
    check("c_full_pending", ll_pending, 2'd2);
    check("c_full_ready",   ll_ready,   1'b0);
    alu_drive(1'b0, 5'd0, '0);
    ll_drive(1'b1, 5'd9, 32'h99);
    cyc();
    check("c_pop7_addr", rf_wr_addr, 5'd7);
    check("c_pop7_data", rf_wr_data, 32'h77);
    check("c_pop7_pending", ll_pending, 2'd1);
    check("c_pop7_ready", ll_ready, 1'b1);
    cyc();
    ll_valid = 1'b0;
    check("c_pop8_addr", rf_wr_addr, 5'd8);
    check("c_pushpop_pending", ll_pending, 2'd1);
    cyc();
    check("c_pop9_addr", rf_wr_addr, 5'd9);
    check("c_pop9_data", rf_wr_data, 32'h99);
    check("c_pop9_pending", ll_pending, 2'd0);

    // ALU write to x0 yields to the queued entry; x0 entries pop silently.
    alu_drive(1'b1, 5'd3, 32'h33);
    ll_drive(1'b1, 5'd4, 32'h44);
    cyc();
    ll_valid = 1'b0;
    alu_drive(1'b1, 5'd0, 32'hBAD);
    cyc();
    check("d_ll_en",      rf_wr_en,   1'b1);
    check("d_ll_addr",    rf_wr_addr, 5'd4);
    check("d_ll_data",    rf_wr_data, 32'h44);
    check("d_ll_pending", ll_pending, 2'd0);
    cyc();
    check("d_no_x0_en",  rf_wr_en,   1'b0);
    check("d_hold_addr", rf_wr_addr, 5'd4);
    check("d_hold_data", rf_wr_data, 32'h44);
    alu_drive(1'b0, 5'd0, '0);
    ll_drive(1'b1, 5'd0, 32'h55);
    cyc();
    ll_valid = 1'b0;
    check("d_rd0_pending", ll_pending, 2'd1);
    cyc();
    check("d_rd0_no_wr",   rf_wr_en,   1'b0);
    check("d_rd0_popped",  ll_pending, 2'd0);
    check("d_rd0_hold",    rf_wr_addr, 5'd4);

    // Reset with two entries queued discards them.
    alu_drive(1'b1, 5'd3, 32'h44);
    ll_drive(1'b1, 5'd12, 32'hC);
    cyc();
    ll_drive(1'b1, 5'd13, 32'hD);
    cyc();
    ll_valid = 1'b0;
    check("e_pending_pre", ll_pending, 2'd2);
    rst = 1'b1;
    #1;
    check_reset_outputs("e_rst");
    alu_drive(1'b0, 5'd0, '0);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("e_post_rst_en", rf_wr_en, 1'b0);
      check("e_post_rst_pending", ll_pending, 2'd0);
    end

    // Random traffic against an in-order scoreboard; upstream obeys stall.
    prev_alu = 1'b0;
    src_hold = 1'b0;
    seq      = 0;
    n_ll_wr  = 0;
    for (int i = 0; i < 400; i++) begin
      rnd_observe();
      alu_drive(wb_stall_req ? 1'b0 : 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), $urandom);
      prev_alu  = alu_wb_rd_wr_en && (alu_wb_rd_addr != 5'd0);
      prev_rd   = alu_wb_rd_addr;
      prev_data = alu_wb_data;
      if (!src_hold) begin
        ll_drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                 32'hC000_0000 | 32'(seq));
        seq++;
      end
      src_hold = ll_valid && !ll_ready;
      if (ll_valid && ll_ready && (ll_rd_addr != 5'd0)) begin
        llq.push_back({ll_rd_addr, ll_data});
      end
      cyc();
    end
    for (int j = 0; j < 8; j++) begin
      rnd_observe();
      alu_drive(1'b0, 5'd0, '0);
      ll_valid = 1'b0;
      prev_alu = 1'b0;
      cyc();
    end
    rnd_observe();
    check("rnd_queue_drained", llq.size(), 0);
    check("rnd_pending_zero", ll_pending, 2'd0);
    check("rnd_ll_writes_seen", n_ll_wr > 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
